// File: rtl/phase_enable_ctrl.sv
// Phase clock-enable scheduler: FETCH/EXEC/MEM/WB tick pulses at a programmable divide
// ratio with a stall/halt handshake. Optional single-phase stepping under PHASE_CTRL_STEP_EN.
module phase_enable_ctrl #(
  parameter int unsigned DIV_W       = 4,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_load,
  input  logic [DIV_W-1:0] div_value,
  output logic             div_busy,
  input  logic             stall_req,
  output logic             stall_ack,
`ifdef PHASE_CTRL_STEP_EN
  input  logic             step,
`endif
  output logic             tick,
  output logic [1:0]       phase,
  output logic             en_fetch,
  output logic             en_exec,
  output logic             en_mem,
  output logic             en_wb
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_HALT
  } state_e;

  localparam logic [DIV_W-1:0] RST_DIV  = DIV_W'(DEFAULT_DIV);
  localparam logic             RST_TICK = (DEFAULT_DIV <= 1);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [1:0]       phase_q, phase_d;
  logic [DIV_W-1:0] div_cur_q, div_cur_d;
  logic [DIV_W-1:0] div_pend_q, div_pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             tick_q, tick_d;
  logic             ack_q, ack_d;
  logic [3:0]       en_q, en_d;
  logic             step_go;

  function automatic logic [DIV_W-1:0] last_cnt(input logic [DIV_W-1:0] d);
    return (d == '0) ? '0 : d - DIV_W'(1);
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    phase_d    = phase_q;
    div_cur_d  = div_cur_q;
    div_pend_d = div_pend_q;
    pend_vld_d = pend_vld_q;
    step_go    = 1'b0;
`ifdef PHASE_CTRL_STEP_EN
    step_go    = step & stall_req;
`endif

    case (state_q)
      ST_RUN, ST_DRAIN: begin
        if (tick_q) begin
          cnt_d   = '0;
          phase_d = phase_q + 2'd1;
          if (phase_q == 2'd3 && pend_vld_q) begin
            div_cur_d  = div_pend_q;
            pend_vld_d = 1'b0;
          end
          if (state_q == ST_DRAIN || stall_req) state_d = ST_HALT;
          else                                  state_d = ST_RUN;
        end else begin
          cnt_d   = cnt_q + DIV_W'(1);
          state_d = stall_req ? ST_DRAIN : ST_RUN;
        end
      end
      ST_HALT: begin
        cnt_d = '0;
        // A step runs one phase through DRAIN, which re-halts on its tick.
        if (!stall_req)  state_d = ST_RUN;
        else if (step_go) state_d = ST_DRAIN;
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase

    // Load decision uses the registered valid so a load coinciding with an apply is dropped.
    if (div_load && !pend_vld_q) begin
      div_pend_d = div_value;
      pend_vld_d = 1'b1;
    end

    // Outputs are registered by evaluating the tick condition on the next state.
    tick_d = (state_d != ST_HALT) && (cnt_d == last_cnt(div_cur_d));
    en_d   = tick_d ? (4'b0001 << phase_d) : 4'b0000;
    ack_d  = (state_d == ST_HALT);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_RUN;
      cnt_q      <= '0;
      phase_q    <= 2'd0;
      div_cur_q  <= RST_DIV;
      div_pend_q <= '0;
      pend_vld_q <= 1'b0;
      tick_q     <= RST_TICK;
      ack_q      <= 1'b0;
      en_q       <= {3'b000, RST_TICK};
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      div_cur_q  <= div_cur_d;
      div_pend_q <= div_pend_d;
      pend_vld_q <= pend_vld_d;
      tick_q     <= tick_d;
      ack_q      <= ack_d;
      en_q       <= en_d;
    end
  end

  assign tick      = tick_q;
  assign phase     = phase_q;
  assign stall_ack = ack_q;
  assign div_busy  = pend_vld_q;
  assign en_fetch  = en_q[0];
  assign en_exec   = en_q[1];
  assign en_mem    = en_q[2];
  assign en_wb     = en_q[3];

endmodule

// File: tb/tb_phase_enable_ctrl.sv
// Bench for phase_enable_ctrl: directed and random stimulus against a phase-countdown model.
module tb_phase_enable_ctrl;

  localparam int unsigned DIV_W = 4;
  localparam int unsigned DEF   = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             div_load;
  logic [DIV_W-1:0] div_value;
  logic             div_busy;
  logic             stall_req;
  logic             stall_ack;
  logic             tick;
  logic [1:0]       phase;
  logic             en_fetch, en_exec, en_mem, en_wb;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc_n    = 0;

  // Model: cycles left in the current phase (tick when 1), halted/draining flags, ratios.
  int m_left, m_phase, m_div, m_pend;
  bit m_pvld, m_halt, m_drain;

  phase_enable_ctrl #(.DIV_W(DIV_W), .DEFAULT_DIV(DEF)) dut (
    .clk       (clk),
    .reset     (reset),
    .div_load  (div_load),
    .div_value (div_value),
    .div_busy  (div_busy),
    .stall_req (stall_req),
    .stall_ack (stall_ack),
`ifdef PHASE_CTRL_STEP_EN
    .step      (1'b0),
`endif
    .tick      (tick),
    .phase     (phase),
    .en_fetch  (en_fetch),
    .en_exec   (en_exec),
    .en_mem    (en_mem),
    .en_wb     (en_wb)
  );

  always #5 clk = ~clk;

  function automatic int eff(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  task automatic m_reset();
    m_phase = 0; m_div = DEF; m_pend = 0; m_pvld = 0;
    m_halt = 0; m_drain = 0; m_left = eff(DEF);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc_n);
    end
  endtask

  task automatic cyc(input bit rst, input bit ld, input int val, input bit sreq);
    bit t, lok;
    logic [3:0] en_exp;
    reset = rst; div_load = ld; div_value = val[DIV_W-1:0]; stall_req = sreq;
    t = !m_halt && (m_left == 1);
    en_exp = t ? (4'b0001 << m_phase) : 4'b0000;
    chk("tick", 8'(tick), 8'(t));
    chk("phase", 8'(phase), 8'(m_phase));
    chk("en", 8'({en_wb, en_mem, en_exec, en_fetch}), 8'(en_exp));
    chk("stall_ack", 8'(stall_ack), 8'(m_halt));
    chk("div_busy", 8'(div_busy), 8'(m_pvld));
    @(posedge clk);
    if (!rst) m_reset();
    else begin
      lok = ld && !m_pvld;
      if (m_halt) begin
        if (!sreq) begin m_halt = 0; m_left = eff(m_div); end
      end else if (t) begin
        if (m_phase == 3 && m_pvld) begin m_div = m_pend; m_pvld = 0; end
        m_phase = (m_phase + 1) % 4;
        m_left  = eff(m_div);
        m_halt  = m_drain || sreq;
        m_drain = 0;
      end else begin
        m_left--;
        m_drain = sreq;
      end
      if (lok) begin m_pend = val % 16; m_pvld = 1; end
    end
    @(negedge clk);
    cyc_n++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0);
  endtask

  initial begin
    bit sr;
    reset = 1'b0; div_load = 1'b0; div_value = '0; stall_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    m_reset();

    // Reset release at the default ratio.
    idle(12);

    // Load 5 during EXEC, then a second load of 3 while busy.
    for (int i = 0; i < 20 && m_phase != 1; i++) cyc(1, 0, 0, 0);
    cyc(1, 1, 5, 0);
    idle(2);
    cyc(1, 1, 3, 0);
    idle(30);

    // Ratio 0 behaves as 1.
    cyc(1, 1, 0, 0);
    idle(30);

    // Ratio 4, stall mid-phase, then release.
    cyc(1, 1, 4, 0);
    idle(30);
    for (int i = 0; i < 10 && m_left != 2; i++) cyc(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(1, 0, 0, 1);
    idle(12);

    // One-cycle stall pulse at phase start: drain returns to run.
    for (int i = 0; i < 10 && m_left != 4; i++) cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 1);
    idle(12);

    // Reset during drain with a pending load.
    for (int i = 0; i < 40 && m_pvld; i++) cyc(1, 0, 0, 0);
    cyc(1, 1, 7, 0);
    for (int i = 0; i < 10 && m_left < 3; i++) cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 1);
    cyc(0, 0, 0, 1);
    idle(10);

    // Random traffic.
    sr = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(5) == 0) sr = ~sr;
      cyc(($urandom_range(120) != 0), ($urandom_range(7) == 0), int'($urandom_range(15)), sr);
    end
    idle(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/phase_enable_ctrl.md
# phase_enable_ctrl

Clock-enable scheduler for the processor datapath. Replaces derived divided clocks with single-cycle enable pulses on the main `clk`, sequencing the four pipeline phases FETCH, EXEC, MEM, WB at a runtime-programmable divide ratio. Provides a stall/halt handshake for the debug and memory controllers. Sits between the top-level clock and every phase-gated register bank.

## Interface

- `DIV_W`, 4: width of the divide-ratio register and phase counter.
- `DEFAULT_DIV`, 2: divide ratio loaded at reset; clk cycles per phase.

- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `div_load`  in  1  one-cycle request to load `div_value`.
- `div_value`  in  DIV_W  new clk cycles per phase; 0 treated as 1.
- `div_busy`  out  1  high while a loaded ratio is pending.
- `stall_req`  in  1  level request to halt at the next phase boundary.
- `stall_ack`  out  1  high while halted.
- `tick`  out  1  one-cycle pulse on the last cycle of each phase.
- `phase`  out  2  current phase: 0 FETCH, 1 EXEC, 2 MEM, 3 WB.
- `en_fetch`, `en_exec`, `en_mem`, `en_wb`  out  1 each  equal to `tick` AND (phase == own phase).

## Operation

- Registers: `cnt` (DIV_W), `phase` (2), `div_cur` (DIV_W), `div_pend` (DIV_W), `pend_vld`, FSM state.
- `div_eff` = max(`div_cur`, 1).
- FSM states:
  - RUN: `cnt` increments each cycle. At `cnt == div_eff-1`: `tick` asserts, `cnt` clears to 0, `phase` increments mod 4.
  - DRAIN: identical counting, entered when `stall_req` is sampled high in RUN on a non-tick cycle.
  - HALT: `cnt` held at 0, `phase` held, no `tick`, `stall_ack` high.
- Transitions:
  - RUN→HALT: `stall_req` high on a tick cycle; that tick still completes.
  - RUN→DRAIN: `stall_req` high on a non-tick cycle.
  - DRAIN→HALT: on the tick cycle.
  - DRAIN→RUN: `stall_req` sampled low before the tick; no ack is produced.
  - HALT→RUN: `stall_req` sampled low; counting resumes from `cnt` 0 in the next cycle.
- Divider load:
  - `div_load` with `pend_vld` clear: latches `div_value` into `div_pend` and sets `pend_vld`.
  - `div_load` with `pend_vld` set: ignored; first pending value wins.
  - Apply point: the WB tick (phase 3→0). `div_cur` ← `div_pend`, `pend_vld` clears, and the new ratio governs the FETCH phase that follows.
  - In HALT, the pending value stays pending until the next WB tick.
  - `div_busy` = `pend_vld`.
- All outputs decode from registers only; there is no combinational input-to-output path.

## Timing

- Reset values: `cnt`=0, `phase`=0, `div_cur`=DEFAULT_DIV, `pend_vld`=0, state RUN. Outputs: `tick`=0, all `en_*`=0, `stall_ack`=0, `div_busy`=0.
- Cycle 0 is the first cycle with `reset` high. First `tick`/`en_fetch` occurs in cycle div_eff-1; tick period is div_eff cycles. With div_eff=1, `tick` is high every cycle.
- `div_busy` rises the cycle after `div_load` and falls the cycle after the applying WB tick.
- `stall_ack`:
  - Rises the cycle after the tick that enters HALT.
  - Falls the cycle after `stall_req` is sampled low.
  - The first tick after release comes div_eff cycles after `stall_ack` falls.
- Reset asserted mid-operation overrides everything in the same edge: pending load discarded, halt cleared.

## Configuration

- `PHASE_CTRL_STEP_EN` defined: adds input `step` (1 bit).
  - A `step` pulse sampled in HALT while `stall_req` is high runs exactly one phase: `stall_ack` drops, div_eff cycles elapse, one tick fires, then HALT is re-entered.
  - `step` outside HALT is ignored.
- `PHASE_CTRL_STEP_EN` undefined: no `step` port; HALT exits only on `stall_req` low.

## Test plan

- Reset release, DEFAULT_DIV=2: `tick` in cycles 1, 3, 5, 7 with `en_fetch`, `en_exec`, `en_mem`, `en_wb` in order; `en_fetch` again in cycle 9.
- `div_load`=1, `div_value`=5 during EXEC of ratio 2: `div_busy` high until the WB tick; the next FETCH lasts 5 cycles; a second `div_load` with value 3 while busy is ignored.
- `div_value`=0 loaded: after the apply point, `tick` is high every cycle and `phase` cycles 0,1,2,3.
- `stall_req` raised mid-phase at ratio 4: the current phase finishes its tick, `stall_ack` rises the next cycle, and `phase` is held. Drop `stall_req`: `stall_ack` falls, and the next tick arrives 4 cycles later on the following phase.
- `stall_req` pulsed high for one non-tick cycle: DRAIN returns to RUN, `stall_ack` never asserts, and tick spacing is unchanged.
- `reset` low for one cycle during DRAIN with a pending load: all outputs return to reset values, `div_busy`=0, and `div_cur`=DEFAULT_DIV.
